// File: rtl/gauss3x3_filter_if.sv
// Column-in / pixel-out bundle for the 3x3 Gaussian filter.
// The line buffer drives the master side; the filter takes the slave side.
interface gauss3x3_filter_if;
    logic [7:0] top;
    logic [7:0] mid;
    logic [7:0] bot;
    logic       valid_in;
    logic       sof_in;
    logic [7:0] pixel_out;
    logic       valid_out;
    logic       eol_out;
    logic       eof_out;

    modport master (
        output top, mid, bot, valid_in, sof_in,
        input  pixel_out, valid_out, eol_out, eof_out
    );

    modport slave (
        input  top, mid, bot, valid_in, sof_in,
        output pixel_out, valid_out, eol_out, eof_out
    );
endinterface

// File: rtl/gauss3x3_filter.sv
// 3x3 Gaussian blur [1 2 1;2 4 2;1 2 1]/16 over a streamed column window.
// Two-register pipeline: window, then sum, then rounded pixel.
module gauss3x3_filter #(
    parameter int W = 64,
    parameter int H = 64
) (
    input logic clk,
    input logic rst_n,
    gauss3x3_filter_if.slave io
);

    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

    logic [CW-1:0] col;
    logic [CW-1:0] cur_col;
    logic [CW-1:0] nxt_col;
    logic [RW-1:0] row;
    logic [RW-1:0] cur_row;
    logic [RW-1:0] nxt_row;
    logic          eligible;
    logic          at_eol;
    logic          at_eof;

    logic [7:0]  win [3][3];
    logic        v1;
    logic        eol1;
    logic        eof1;

    logic [11:0] sum_c;
    logic [11:0] sum_r;
    logic        v2;
    logic        eol2;
    logic        eof2;

    logic [7:0]  pix_c;
    logic [7:0]  pixel_q;
    logic        valid_q;
    logic        eol_q;
    logic        eof_q;

    // sof_in forces the accepted column to (0,0) whatever the counters say
    always_comb begin
        cur_col  = io.sof_in ? '0 : col;
        cur_row  = io.sof_in ? '0 : row;
        nxt_col  = cur_col + CW'(1);
        nxt_row  = cur_row;
        if (cur_col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end
        eligible = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        at_eol   = (cur_col == COL_LAST);
        at_eof   = at_eol && (cur_row == ROW_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (io.valid_in) begin
            col <= nxt_col;
            row <= nxt_row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (io.valid_in) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= io.top;
            win[1][2] <= io.mid;
            win[2][2] <= io.bot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            eol1 <= 1'b0;
            eof1 <= 1'b0;
        end else begin
            v1   <= io.valid_in && eligible;
            eol1 <= io.valid_in && eligible && at_eol;
            eof1 <= io.valid_in && eligible && at_eof;
        end
    end

    // Worst case 16*255 = 4080 still fits in 12 bits
    always_comb begin
        sum_c = 12'(win[0][0])
              + (12'(win[0][1]) << 1)
              + 12'(win[0][2])
              + (12'(win[1][0]) << 1)
              + (12'(win[1][1]) << 2)
              + (12'(win[1][2]) << 1)
              + 12'(win[2][0])
              + (12'(win[2][1]) << 1)
              + 12'(win[2][2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= '0;
            v2    <= 1'b0;
            eol2  <= 1'b0;
            eof2  <= 1'b0;
        end else begin
            sum_r <= sum_c;
            v2    <= v1;
            eol2  <= eol1;
            eof2  <= eof1;
        end
    end

    assign pix_c = 8'((sum_r + 12'd8) >> 4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= '0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            valid_q <= v2;
            eol_q   <= eol2;
            eof_q   <= eof2;
            if (v2) begin
                pixel_q <= pix_c;
            end
        end
    end

    assign io.pixel_out = pixel_q;
    assign io.valid_out = valid_q;
    assign io.eol_out   = eol_q;
    assign io.eof_out   = eof_q;

endmodule
